// File: rtl/ahb_lite_cmd_master.sv
// AHB-Lite initiator: turns valid/ready read/write commands into pipelined NONSEQ transfers,
// with ERROR-response cancellation and a data-phase wait-state watchdog.
module ahb_lite_cmd_master #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  HCLK,
    input  logic                  HRESET,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [2:0]            cmd_size,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,

    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_cancel,
    output logic                  rsp_timeout,

    output logic                  HSEL,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic                  HMASTLOCK,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HRESP
);

    // The counter only has to reach TIMEOUT_CYCLES-1; the firing cycle is the TIMEOUT_CYCLES-th wait.
    localparam int unsigned    CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit             WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] WD_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StErr1   = 2'd1,
        StCancel = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic                  live_q;
    logic                  halted_q;

    logic                  aph_valid_q;
    logic                  aph_cancel_q;
    logic                  aph_write_q;
    logic [ADDR_WIDTH-1:0] aph_addr_q;
    logic [2:0]            aph_size_q;
    logic [DATA_WIDTH-1:0] aph_wdata_q;

    logic                  dph_valid_q;
    logic                  dph_write_q;
    logic [DATA_WIDTH-1:0] hwdata_q;

    logic [CNT_W-1:0]      wd_cnt_q;

    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic                  rsp_cancel_q;
    logic                  rsp_timeout_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;

    logic cmd_ready_c;
    logic cmd_acc;
    logic aph_adv;
    logic dph_done;
    logic dph_wait;
    logic wd_fire;
    logic err_start;
    logic cancel_emit;

    always_comb begin
        state_d     = state_q;
        cmd_ready_c = 1'b0;
        err_start   = 1'b0;
        cancel_emit = 1'b0;
        dph_wait    = dph_valid_q & ~HREADY;
        dph_done    = dph_valid_q & HREADY;
        wd_fire     = WD_EN & dph_wait & (wd_cnt_q == WD_LAST);

        case (state_q)
            StRun: begin
                cmd_ready_c = live_q & (~aph_valid_q | HREADY);
                if (dph_valid_q & HRESP & ~HREADY) begin
                    err_start = 1'b1;
                    state_d   = StErr1;
                end
            end
            StErr1: begin
                // Any APH content here was marked cancelled on entry.
                if (HREADY) begin
                    state_d = aph_valid_q ? StCancel : StRun;
                end
            end
            StCancel: begin
                cancel_emit = 1'b1;
                state_d     = StRun;
            end
            default: state_d = StRun;
        endcase

        cmd_acc = cmd_valid & cmd_ready_c;
        aph_adv = aph_valid_q & ~aph_cancel_q & HREADY;

        if (wd_fire) begin
            err_start = 1'b0;
            state_d   = (aph_valid_q | cmd_acc) ? StCancel : StRun;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            live_q        <= 1'b0;
            halted_q      <= 1'b0;
            aph_valid_q   <= 1'b0;
            aph_cancel_q  <= 1'b0;
            aph_write_q   <= 1'b0;
            aph_addr_q    <= '0;
            aph_size_q    <= '0;
            aph_wdata_q   <= '0;
            dph_valid_q   <= 1'b0;
            dph_write_q   <= 1'b0;
            hwdata_q      <= '0;
            wd_cnt_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_cancel_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
        end else begin
            // A timeout leaves the slave stalled, so command intake stays off until reset.
            live_q   <= wd_fire ? 1'b0 : (live_q | ~halted_q);
            halted_q <= halted_q | wd_fire;

            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_cancel_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
            if (dph_done) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= HRESP | (state_q == StErr1);
                rsp_rdata_q <= (~dph_write_q & ~HRESP & (state_q != StErr1)) ? HRDATA : '0;
            end else if (wd_fire) begin
                rsp_valid_q   <= 1'b1;
                rsp_err_q     <= 1'b1;
                rsp_timeout_q <= 1'b1;
                rsp_rdata_q   <= '0;
            end else if (cancel_emit) begin
                rsp_valid_q  <= 1'b1;
                rsp_err_q    <= 1'b1;
                rsp_cancel_q <= 1'b1;
                rsp_rdata_q  <= '0;
            end

            if (cmd_acc) begin
                aph_valid_q  <= 1'b1;
                aph_cancel_q <= err_start | wd_fire;
                aph_write_q  <= cmd_write;
                aph_addr_q   <= cmd_addr;
                aph_size_q   <= cmd_size;
                aph_wdata_q  <= cmd_wdata;
            end else if (aph_adv | cancel_emit) begin
                aph_valid_q  <= 1'b0;
                aph_cancel_q <= 1'b0;
            end else if ((err_start | wd_fire) & aph_valid_q) begin
                aph_cancel_q <= 1'b1;
            end

            if (wd_fire) begin
                dph_valid_q <= 1'b0;
            end else if (aph_adv) begin
                dph_valid_q <= 1'b1;
                dph_write_q <= aph_write_q;
                hwdata_q    <= aph_wdata_q;
            end else if (dph_done) begin
                dph_valid_q <= 1'b0;
            end

            wd_cnt_q <= (dph_wait & ~wd_fire) ? (wd_cnt_q + 1'b1) : '0;
        end
    end

    assign cmd_ready   = cmd_ready_c;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_cancel  = rsp_cancel_q;
    assign rsp_timeout = rsp_timeout_q;

    assign HSEL      = aph_valid_q & ~aph_cancel_q;
    assign HTRANS    = {aph_valid_q & ~aph_cancel_q, 1'b0};
    assign HADDR     = aph_addr_q;
    assign HWRITE    = aph_write_q;
    assign HSIZE     = aph_size_q;
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;
    assign HWDATA    = hwdata_q;

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// Directed bench for ahb_lite_cmd_master; the bench itself plays the AHB slave cycle by cycle.
module tb_ahb_lite_cmd_master;

    logic        HCLK;
    logic        HRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_cancel;
    logic        rsp_timeout;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HRESP;

    int n_assert;
    int n_fail;
    int rsp_cnt;
    int cnt0;
    logic [7:0] tsr;

    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    ahb_lite_cmd_master #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_size   (cmd_size),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_cancel (rsp_cancel),
        .rsp_timeout(rsp_timeout),
        .HSEL       (HSEL),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HWRITE     (HWRITE),
        .HSIZE      (HSIZE),
        .HBURST     (HBURST),
        .HPROT      (HPROT),
        .HMASTLOCK  (HMASTLOCK),
        .HWDATA     (HWDATA),
        .HREADY     (HREADY),
        .HRDATA     (HRDATA),
        .HRESP      (HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial rsp_cnt = 0;
    always @(negedge HCLK) begin
        if (rsp_valid === 1'b1) rsp_cnt = rsp_cnt + 1;
    end

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic w, input logic [31:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_size  = 3'b000;
        cmd_wdata = d;
    endtask

    task automatic idle_cmd;
        cmd_valid = 1'b0;
    endtask

    task automatic bus(input logic rdy, input logic resp, input logic [31:0] rd);
        HREADY = rdy;
        HRESP  = resp;
        HRDATA = rd;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        tsr       = 8'h00;
        HRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_size  = '0;
        cmd_wdata = '0;
        HREADY    = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = JUNK;
        tick;
        tick;

        // Reset values
        chk("rst_htrans",    64'(HTRANS),    64'h0);
        chk("rst_hsel",      64'(HSEL),      64'h0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_hwdata",    64'(HWDATA),    64'h0);
        chk("rst_haddr",     64'(HADDR),     64'h0);
        HRESET = 1'b0;
        #1;
        chk("ready_before_edge", 64'(cmd_ready), 64'h0);
        tick;
        chk("ready_after_edge", 64'(cmd_ready), 64'h1);
        chk("hburst", 64'(HBURST),    64'h0);
        chk("hprot",  64'(HPROT),     64'h3);
        chk("hlock",  64'(HMASTLOCK), 64'h0);

        // Single write, zero wait states
        offer(1'b1, 32'hC010_0000, 32'h0000_00FF);
        #1;
        chk("t1_ready", 64'(cmd_ready), 64'h1);
        tick;
        idle_cmd;
        bus(1'b1, 1'b0, JUNK);
        chk("t1_htrans", 64'(HTRANS), 64'h2);
        chk("t1_hsel",   64'(HSEL),   64'h1);
        chk("t1_haddr",  64'(HADDR),  64'hC010_0000);
        chk("t1_hwrite", 64'(HWRITE), 64'h1);
        chk("t1_rsp_early", 64'(rsp_valid), 64'h0);
        tick;
        chk("t1_htrans_idle", 64'(HTRANS), 64'h0);
        chk("t1_hwdata", 64'(HWDATA), 64'hFF);
        chk("t1_rsp_early2", 64'(rsp_valid), 64'h0);
        tick;
        chk("t1_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("t1_rsp_err",   64'(rsp_err),   64'h0);
        chk("t1_rsp_rdata", 64'(rsp_rdata), 64'h0);
        tick;
        chk("t1_rsp_pulse", 64'(rsp_valid), 64'h0);

        // Timer flow: TCR write, underflow, TSR read/clear/re-read
        offer(1'b1, 32'hC010_0001, 32'h0000_0030);
        tick;
        idle_cmd;
        tick;
        chk("t2_tcr_hwdata", 64'(HWDATA), 64'h30);
        tick;
        chk("t2_tcr_rsp", 64'(rsp_valid), 64'h1);
        chk("t2_tcr_err", 64'(rsp_err),   64'h0);
        repeat (12) tick;
        tsr = 8'h02;
        offer(1'b0, 32'hC010_0002, 32'h0);
        tick;
        idle_cmd;
        chk("t2_rd_hwrite", 64'(HWRITE), 64'h0);
        chk("t2_rd_haddr",  64'(HADDR),  64'hC010_0002);
        tick;
        bus(1'b1, 1'b0, {24'h0, tsr});
        tick;
        bus(1'b1, 1'b0, JUNK);
        chk("t2_rd_valid", 64'(rsp_valid), 64'h1);
        chk("t2_rd_data",  64'(rsp_rdata), 64'h02);
        offer(1'b1, 32'hC010_0002, 32'h0000_0000);
        tick;
        idle_cmd;
        tick;
        tsr = HWDATA[7:0];
        chk("t2_clr_hwdata", 64'(HWDATA), 64'h0);
        tick;
        chk("t2_clr_rsp",   64'(rsp_valid), 64'h1);
        chk("t2_clr_rdata", 64'(rsp_rdata), 64'h0);
        offer(1'b0, 32'hC010_0002, 32'h0);
        tick;
        idle_cmd;
        tick;
        bus(1'b1, 1'b0, {24'h0, tsr});
        tick;
        bus(1'b1, 1'b0, JUNK);
        chk("t2_rerd_valid", 64'(rsp_valid), 64'h1);
        chk("t2_rerd_data",  64'(rsp_rdata), 64'h00);
        tick;

        // Four back-to-back commands with one wait state per data phase
        cnt0 = rsp_cnt;
        offer(1'b1, 32'hC010_0000, 32'h11);
        bus(1'b1, 1'b0, JUNK);
        tick;
        offer(1'b0, 32'hC010_0004, 32'h0);
        bus(1'b1, 1'b0, JUNK);
        chk("t3_ready_c1", 64'(cmd_ready), 64'h1);
        chk("t3_haddr0",   64'(HADDR),     64'hC010_0000);
        tick;
        offer(1'b1, 32'hC010_0008, 32'h33);
        bus(1'b0, 1'b0, JUNK);
        chk("t3_haddr1",      64'(HADDR),     64'hC010_0004);
        chk("t3_hwdata0",     64'(HWDATA),    64'h11);
        chk("t3_ready_wait",  64'(cmd_ready), 64'h0);
        tick;
        bus(1'b1, 1'b0, JUNK);
        chk("t3_haddr1_held",  64'(HADDR),  64'hC010_0004);
        chk("t3_htrans_held",  64'(HTRANS), 64'h2);
        tick;
        offer(1'b0, 32'hC010_000C, 32'h0);
        bus(1'b0, 1'b0, JUNK);
        chk("t3_rsp0_valid", 64'(rsp_valid), 64'h1);
        chk("t3_rsp0_rdata", 64'(rsp_rdata), 64'h0);
        chk("t3_haddr2",     64'(HADDR),     64'hC010_0008);
        tick;
        bus(1'b1, 1'b0, 32'h22);
        chk("t3_rsp_gap", 64'(rsp_valid), 64'h0);
        tick;
        idle_cmd;
        bus(1'b0, 1'b0, JUNK);
        chk("t3_rsp1_valid", 64'(rsp_valid), 64'h1);
        chk("t3_rsp1_rdata", 64'(rsp_rdata), 64'h22);
        chk("t3_haddr3",     64'(HADDR),     64'hC010_000C);
        chk("t3_hwdata2",    64'(HWDATA),    64'h33);
        tick;
        bus(1'b1, 1'b0, JUNK);
        tick;
        bus(1'b0, 1'b0, JUNK);
        chk("t3_rsp2_valid", 64'(rsp_valid), 64'h1);
        chk("t3_rsp2_rdata", 64'(rsp_rdata), 64'h0);
        chk("t3_idle",       64'(HTRANS),    64'h0);
        tick;
        bus(1'b1, 1'b0, 32'h44);
        tick;
        bus(1'b1, 1'b0, JUNK);
        chk("t3_rsp3_valid", 64'(rsp_valid), 64'h1);
        chk("t3_rsp3_rdata", 64'(rsp_rdata), 64'h44);
        tick;
        chk("t3_rsp_count", 64'(rsp_cnt - cnt0), 64'h4);

        // ERROR on a write with a read pipelined behind it
        offer(1'b1, 32'hC010_0010, 32'h55);
        tick;
        offer(1'b0, 32'hC010_0014, 32'h0);
        tick;
        idle_cmd;
        bus(1'b0, 1'b1, JUNK);
        chk("t4_err1_htrans", 64'(HTRANS),    64'h2);
        chk("t4_err1_ready",  64'(cmd_ready), 64'h0);
        tick;
        bus(1'b1, 1'b1, JUNK);
        chk("t4_err2_htrans", 64'(HTRANS),    64'h0);
        chk("t4_err2_hsel",   64'(HSEL),      64'h0);
        chk("t4_err2_ready",  64'(cmd_ready), 64'h0);
        tick;
        bus(1'b1, 1'b0, JUNK);
        chk("t4_rsp_valid",  64'(rsp_valid),  64'h1);
        chk("t4_rsp_err",    64'(rsp_err),    64'h1);
        chk("t4_rsp_cancel", 64'(rsp_cancel), 64'h0);
        chk("t4_ready_cxl",  64'(cmd_ready),  64'h0);
        tick;
        chk("t4_cxl_valid",  64'(rsp_valid),  64'h1);
        chk("t4_cxl_err",    64'(rsp_err),    64'h1);
        chk("t4_cxl_cancel", 64'(rsp_cancel), 64'h1);
        chk("t4_cxl_rdata",  64'(rsp_rdata),  64'h0);
        chk("t4_ready_back", 64'(cmd_ready),  64'h1);
        tick;
        chk("t4_rsp_done", 64'(rsp_valid), 64'h0);

        // ERROR without the preceding wait cycle
        offer(1'b0, 32'hC010_0018, 32'h0);
        tick;
        idle_cmd;
        tick;
        bus(1'b1, 1'b1, 32'h77);
        tick;
        bus(1'b1, 1'b0, JUNK);
        chk("pv_valid",  64'(rsp_valid),  64'h1);
        chk("pv_err",    64'(rsp_err),    64'h1);
        chk("pv_cancel", 64'(rsp_cancel), 64'h0);
        chk("pv_rdata",  64'(rsp_rdata),  64'h0);
        chk("pv_ready",  64'(cmd_ready),  64'h1);
        tick;

        // Watchdog: 8 wait cycles, with a second read queued behind
        offer(1'b0, 32'hC010_0020, 32'h0);
        tick;
        offer(1'b0, 32'hC010_0024, 32'h0);
        tick;
        idle_cmd;
        bus(1'b0, 1'b0, JUNK);
        chk("t5_queued_htrans", 64'(HTRANS), 64'h2);
        for (int i = 0; i < 8; i++) begin
            chk("t5_no_rsp", 64'(rsp_valid), 64'h0);
            tick;
        end
        chk("t5_to_valid",   64'(rsp_valid),   64'h1);
        chk("t5_to_err",     64'(rsp_err),     64'h1);
        chk("t5_to_timeout", 64'(rsp_timeout), 64'h1);
        chk("t5_to_cancel",  64'(rsp_cancel),  64'h0);
        chk("t5_to_htrans",  64'(HTRANS),      64'h0);
        tick;
        chk("t5_cxl_valid",   64'(rsp_valid),   64'h1);
        chk("t5_cxl_cancel",  64'(rsp_cancel),  64'h1);
        chk("t5_cxl_timeout", 64'(rsp_timeout), 64'h0);
        tick;
        bus(1'b1, 1'b0, JUNK);
        chk("t5_halt_ready",  64'(cmd_ready), 64'h0);
        chk("t5_halt_htrans", 64'(HTRANS),    64'h0);
        chk("t5_halt_rsp",    64'(rsp_valid), 64'h0);

        // Recover with reset, then reset again in the middle of a data-phase wait
        HRESET = 1'b1;
        tick;
        HRESET = 1'b0;
        tick;
        offer(1'b1, 32'hC010_0030, 32'hA5);
        #1;
        chk("t6_ready", 64'(cmd_ready), 64'h1);
        tick;
        idle_cmd;
        tick;
        bus(1'b0, 1'b0, JUNK);
        chk("t6_hwdata", 64'(HWDATA), 64'hA5);
        cnt0 = rsp_cnt;
        HRESET = 1'b1;
        #1;
        chk("t6_async_htrans", 64'(HTRANS),    64'h0);
        chk("t6_async_hsel",   64'(HSEL),      64'h0);
        chk("t6_async_hwdata", 64'(HWDATA),    64'h0);
        chk("t6_async_haddr",  64'(HADDR),     64'h0);
        chk("t6_async_ready",  64'(cmd_ready), 64'h0);
        chk("t6_async_rsp",    64'(rsp_valid), 64'h0);
        bus(1'b1, 1'b0, JUNK);
        tick;
        tick;
        chk("t6_rst_rsp", 64'(rsp_valid), 64'h0);
        HRESET = 1'b0;
        #1;
        chk("t6_ready_pre", 64'(cmd_ready), 64'h0);
        tick;
        chk("t6_ready_post", 64'(cmd_ready), 64'h1);
        chk("t6_no_rsp_cnt", 64'(rsp_cnt - cnt0), 64'h0);
        offer(1'b0, 32'hC010_0034, 32'h0);
        tick;
        idle_cmd;
        tick;
        bus(1'b1, 1'b0, 32'h5A);
        tick;
        bus(1'b1, 1'b0, JUNK);
        chk("t6_rd_valid", 64'(rsp_valid), 64'h1);
        chk("t6_rd_err",   64'(rsp_err),   64'h0);
        chk("t6_rd_data",  64'(rsp_rdata), 64'h5A);
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
